token_field_decoder: RTL and testbench

//  Serial token-field stage directly downstream of pid_block in the SIE receive path.
//  On a token PID it collects the 16 following bits from the same serial stream, LSB first.
//  The bits form 11 field bits (ADDR[6:0], ENDP[3:0], or FRAME[10:0] for SOF) plus CRC5.
//  It checks CRC5 and presents a registered, qualified token to the endpoint/protocol layer.

---
 rtl/usb_sie_pkg.sv | 39 +++
 rtl/crc5_serial.sv | 24 ++
 rtl/token_field_decoder.sv | 147 ++++++++++++++
 tb/tb_token_field_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_sie_pkg.sv
// Shared definitions for the SIE receive path (pid_block, token_field_decoder)
// and the transmit-side token generator.
package usb_sie_pkg;

  // PID codes (4-bit PID, check nibble handled in pid_block)
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Token geometry
  localparam int FIELD_BITS = 11;
  localparam int CRC_BITS   = 5;

  // CRC5: x^5 + x^2 + 1, bit i = coefficient of x^i
  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
  localparam logic [4:0] CRC5_INIT     = 5'b11111;

  // Token decoder state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } tfd_state_e;

  // One serial CRC5 step: feedback is the incoming bit XOR the register MSB
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[4];
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

endpackage

// File: rtl/crc5_serial.sv
// Bit-serial CRC5 engine; init has priority over en.
module crc5_serial
  import usb_sie_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       init,
  input  logic       en,
  input  logic       din,
  output logic [4:0] crc
);

  // Seed on init, otherwise advance one bit whenever en is high
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      crc <= CRC5_INIT;
    end else if (init) begin
      crc <= CRC5_INIT;
    end else if (en) begin
      crc <= crc5_step(crc, din);
    end
  end

endmodule

// File: rtl/token_field_decoder.sv
// Collects the 16 bits following a token PID, checks CRC5 and presents the
// qualified address/endpoint or frame number with a one-cycle pulse.
module token_field_decoder
  import usb_sie_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RST,
  input  logic        DATA_IN,
  input  logic        TOKEN_START,
  input  logic        IS_SOF,
  input  logic        EOP,
  output logic [6:0]  ADDR,
  output logic [3:0]  ENDP,
  output logic [10:0] FRAME,
  output logic        TOKEN_VALID,
  output logic        SOF_VALID,
  output logic        CRC_ERROR,
  output logic        LEN_ERROR,
  output logic        BUSY
);

  localparam logic [3:0] LAST_BIT  = 4'd15;
  localparam logic [3:0] FIELD_CNT = 4'(FIELD_BITS);

  tfd_state_e              state, state_next;
  logic [3:0]              cnt;
  logic [FIELD_BITS-1:0]   field_sreg;
  logic                    is_sof_q;
  logic [4:0]              crc;
  logic                    start_token;
  logic                    shift_en;
  logic                    token_valid_next;
  logic                    sof_valid_next;
  logic                    crc_error_next;
  logic                    len_error_next;

  crc5_serial u_crc5 (
    .CLOCK (CLOCK),
    .RST   (RST),
    .init  (start_token),
    .en    (shift_en),
    .din   (DATA_IN),
    .crc   (crc)
  );

  // Next state and pulse decode; a new TOKEN_START always restarts collection
  always_comb begin
    state_next       = state;
    start_token      = 1'b0;
    shift_en         = 1'b0;
    token_valid_next = 1'b0;
    sof_valid_next   = 1'b0;
    crc_error_next   = 1'b0;
    len_error_next   = 1'b0;
    case (state)
      IDLE: begin
        if (TOKEN_START) begin
          start_token = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (TOKEN_START) begin
          start_token = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (cnt == LAST_BIT) begin
            state_next = CHECK;
          end else if (EOP) begin
            len_error_next = 1'b1;
            state_next     = IDLE;
          end
        end
      end
      CHECK: begin
        if (TOKEN_START) begin
          start_token = 1'b1;
          state_next  = SHIFT;
        end else begin
          state_next = IDLE;
          if (crc == CRC5_RESIDUAL) begin
            sof_valid_next   = is_sof_q;
            token_valid_next = !is_sof_q;
          end else begin
            crc_error_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered result pulses
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      TOKEN_VALID <= 1'b0;
      SOF_VALID   <= 1'b0;
      CRC_ERROR   <= 1'b0;
      LEN_ERROR   <= 1'b0;
    end else begin
      state       <= state_next;
      TOKEN_VALID <= token_valid_next;
      SOF_VALID   <= sof_valid_next;
      CRC_ERROR   <= crc_error_next;
      LEN_ERROR   <= len_error_next;
    end
  end

  // Bit counter and field capture; the CRC bits only feed the CRC engine,
  // so just the first 11 bits are kept, landing LSB-first in field_sreg
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      cnt        <= 4'd0;
      field_sreg <= '0;
      is_sof_q   <= 1'b0;
    end else if (start_token) begin
      cnt      <= 4'd0;
      is_sof_q <= IS_SOF;
    end else if (shift_en) begin
      cnt <= cnt + 4'd1;
      if (cnt < FIELD_CNT) begin
        field_sreg <= {DATA_IN, field_sreg[FIELD_BITS-1:1]};
      end
    end
  end

  // Result registers change only together with a good-token pulse
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      ADDR  <= 7'd0;
      ENDP  <= 4'd0;
      FRAME <= 11'd0;
    end else begin
      if (token_valid_next) begin
        ADDR <= field_sreg[6:0];
        ENDP <= field_sreg[10:7];
      end
      if (sof_valid_next) begin
        FRAME <= field_sreg;
      end
    end
  end

  assign BUSY = (state == SHIFT);

endmodule

// File: tb/tb_token_field_decoder.sv
// Directed self-checking bench for token_field_decoder.
module tb_token_field_decoder;

  logic        CLOCK = 1'b0;
  logic        RST = 1'b0;
  logic        DATA_IN = 1'b0;
  logic        TOKEN_START = 1'b0;
  logic        IS_SOF = 1'b0;
  logic        EOP = 1'b0;
  logic [6:0]  ADDR;
  logic [3:0]  ENDP;
  logic [10:0] FRAME;
  logic        TOKEN_VALID;
  logic        SOF_VALID;
  logic        CRC_ERROR;
  logic        LEN_ERROR;
  logic        BUSY;

  int check_count = 0;
  int error_count = 0;
  int tok_seen = 0;
  int sof_seen = 0;
  int crc_seen = 0;
  int len_seen = 0;
  int multi_seen = 0;

  logic [15:0] pkt;

  token_field_decoder dut (
    .CLOCK       (CLOCK),
    .RST         (RST),
    .DATA_IN     (DATA_IN),
    .TOKEN_START (TOKEN_START),
    .IS_SOF      (IS_SOF),
    .EOP         (EOP),
    .ADDR        (ADDR),
    .ENDP        (ENDP),
    .FRAME       (FRAME),
    .TOKEN_VALID (TOKEN_VALID),
    .SOF_VALID   (SOF_VALID),
    .CRC_ERROR   (CRC_ERROR),
    .LEN_ERROR   (LEN_ERROR),
    .BUSY        (BUSY)
  );

  // 100 MHz clock
  always #5 CLOCK = ~CLOCK;

  // Pulse monitor sampled on the falling edge, away from the active edge
  always @(negedge CLOCK) begin
    if (RST) begin
      if (TOKEN_VALID) tok_seen++;
      if (SOF_VALID)   sof_seen++;
      if (CRC_ERROR)   crc_seen++;
      if (LEN_ERROR)   len_seen++;
      if ((32'(TOKEN_VALID) + 32'(SOF_VALID) + 32'(CRC_ERROR) + 32'(LEN_ERROR)) > 1)
        multi_seen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Transmit-side reference: USB CRC5 over the 11 field bits, sent inverted MSB first
  function automatic logic [15:0] makePacket(input logic [10:0] field);
    logic [4:0]  r;
    logic [15:0] p;
    r = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      if (field[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else                 r = {r[3:0], 1'b0};
    end
    p[10:0] = field;
    for (int j = 0; j < 5; j++) p[11+j] = ~r[4-j];
    return p;
  endfunction

  // TOKEN_START pulse, then n_bits LSB-first; optional EOP alongside the last bit
  task automatic applyStimulus(input logic is_sof, input logic [15:0] bits,
                               input int n_bits, input logic eop_on_last);
    TOKEN_START = 1'b1;
    IS_SOF      = is_sof;
    tick();
    TOKEN_START = 1'b0;
    IS_SOF      = 1'b0;
    for (int i = 0; i < n_bits; i++) begin
      DATA_IN = bits[i];
      EOP     = eop_on_last && (i == n_bits - 1);
      tick();
    end
    DATA_IN = 1'b0;
    EOP     = 1'b0;
  endtask

  function automatic logic [31:0] pulseCounts();
    return {8'(tok_seen), 8'(sof_seen), 8'(crc_seen), 8'(len_seen)};
  endfunction

  function automatic logic [4:0] flags();
    return {TOKEN_VALID, SOF_VALID, CRC_ERROR, LEN_ERROR, BUSY};
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    checkOutput("reset_flags", 32'(flags()), 32'h0);
    checkOutput("reset_addr_endp_frame", {10'd0, ADDR, ENDP, FRAME}, 32'h0);
    RST = 1'b1;
    tick();

    // 1: SETUP addr0/ep0, bytes 0x00 0x10
    applyStimulus(1'b0, 16'h1000, 16, 1'b0);
    checkOutput("t1_busy_in_check", 32'(BUSY), 32'h0);
    tick();
    checkOutput("t1_flags", 32'(flags()), 32'b10000);
    checkOutput("t1_addr_endp", {ADDR, ENDP}, {7'h00, 4'h0});
    tick();
    checkOutput("t1_pulse_width", 32'(flags()), 32'h0);
    checkOutput("t1_counts", pulseCounts(), {8'd1, 8'd0, 8'd0, 8'd0});

    // 2: second byte 0x11, ENDP bit flipped
    applyStimulus(1'b0, 16'h1100, 16, 1'b0);
    tick();
    checkOutput("t2_flags", 32'(flags()), 32'b00100);
    checkOutput("t2_addr_endp_hold", {ADDR, ENDP}, {7'h00, 4'h0});
    tick();
    checkOutput("t2_counts", pulseCounts(), {8'd1, 8'd0, 8'd1, 8'd0});

    // 3: SOF frame 0x7FF
    pkt = makePacket(11'h7FF);
    applyStimulus(1'b1, pkt, 16, 1'b0);
    tick();
    checkOutput("t3_flags", 32'(flags()), 32'b01000);
    checkOutput("t3_frame", 32'(FRAME), 32'h7FF);
    checkOutput("t3_addr_endp_hold", {ADDR, ENDP}, {7'h00, 4'h0});
    tick();
    checkOutput("t3_counts", pulseCounts(), {8'd1, 8'd1, 8'd1, 8'd0});

    // 4: EOP after 9 field bits
    applyStimulus(1'b0, 16'h01AB, 9, 1'b0);
    checkOutput("t4_busy_before", 32'(BUSY), 32'h1);
    EOP = 1'b1;
    tick();
    EOP = 1'b0;
    checkOutput("t4_flags", 32'(flags()), 32'b00010);
    tick();
    checkOutput("t4_pulse_width", 32'(flags()), 32'h0);
    checkOutput("t4_counts", pulseCounts(), {8'd1, 8'd1, 8'd1, 8'd1});

    // 5: restart after 6 bits, then good token ADDR 0x15 ENDP 0xA
    applyStimulus(1'b0, 16'h002A, 6, 1'b0);
    pkt = makePacket({4'hA, 7'h15});
    applyStimulus(1'b0, pkt, 16, 1'b0);
    tick();
    checkOutput("t5_flags", 32'(flags()), 32'b10000);
    checkOutput("t5_addr_endp", {ADDR, ENDP}, {7'h15, 4'hA});
    checkOutput("t5_frame_hold", 32'(FRAME), 32'h7FF);
    tick();
    checkOutput("t5_counts", pulseCounts(), {8'd2, 8'd1, 8'd1, 8'd1});

    // EOP alongside the 16th bit is ignored
    pkt = makePacket({4'h3, 7'h7F});
    applyStimulus(1'b0, pkt, 16, 1'b1);
    tick();
    checkOutput("eop16_flags", 32'(flags()), 32'b10000);
    checkOutput("eop16_addr_endp", {ADDR, ENDP}, {7'h7F, 4'h3});
    tick();

    // Corrupted token must leave ADDR/ENDP untouched
    pkt = makePacket({4'h2, 7'h01}) ^ 16'h0004;
    applyStimulus(1'b0, pkt, 16, 1'b0);
    tick();
    checkOutput("bad_tok_flags", 32'(flags()), 32'b00100);
    checkOutput("bad_tok_hold", {ADDR, ENDP}, {7'h7F, 4'h3});
    tick();

    // Corrupted SOF must leave FRAME untouched
    pkt = makePacket(11'h123) ^ 16'h4000;
    applyStimulus(1'b1, pkt, 16, 1'b0);
    tick();
    checkOutput("bad_sof_flags", 32'(flags()), 32'b00100);
    checkOutput("bad_sof_hold", 32'(FRAME), 32'h7FF);
    tick();

    // EOP while idle is ignored
    EOP = 1'b1;
    tick();
    EOP = 1'b0;
    tick();
    checkOutput("eop_idle_flags", 32'(flags()), 32'h0);
    checkOutput("pre_reset_counts", pulseCounts(), {8'd3, 8'd1, 8'd3, 8'd1});

    // 6: reset after 10 bits, then 20 idle cycles
    applyStimulus(1'b0, makePacket({4'h5, 7'h2A}), 10, 1'b0);
    checkOutput("t6_busy_before", 32'(BUSY), 32'h1);
    RST = 1'b0;
    #2;
    checkOutput("t6_async_flags", 32'(flags()), 32'h0);
    checkOutput("t6_async_regs", {10'd0, ADDR, ENDP, FRAME}, 32'h0);
    tick();
    tick();
    RST = 1'b1;
    repeat (20) tick();
    checkOutput("t6_flags", 32'(flags()), 32'h0);
    checkOutput("t6_regs", {10'd0, ADDR, ENDP, FRAME}, 32'h0);
    checkOutput("t6_counts", pulseCounts(), {8'd3, 8'd1, 8'd3, 8'd1});

    checkOutput("pulse_exclusive", 32'(multi_seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
